// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 4-digit common-anode FND driver with a blanking gap per slot.
// Optional leading-zero blanking is compiled in when FND_LZB_EN is defined.
module fnd_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_blank,
    input  logic [7:0] i_font0,
    input  logic [7:0] i_font1,
    input  logic [7:0] i_font2,
    input  logic [7:0] i_font3,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_font,
    output logic [1:0] o_digit_idx,
    output logic       o_frame_tick
);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [23:0] CNT_LAST   = 24'(SCAN_DIV - 1);
    localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic [3:0]  com_q, com_d;
    logic [7:0]  font_q, font_d;
    logic        tick_q, tick_d;
    logic [7:0]  font_sel;
    logic [7:0]  latch_font;

    always_comb begin
        case (idx_q)
            2'd0:    font_sel = i_font0;
            2'd1:    font_sel = i_font1;
            2'd2:    font_sel = i_font2;
            default: font_sel = i_font3;
        endcase
    end

`ifdef FND_LZB_EN
    // A digit is a leading zero only if it and every digit to its left show a plain "0".
    logic [3:0] is_zero;
    logic       lead_zero;
    assign is_zero = {i_font3 == 8'hc0, i_font2 == 8'hc0, i_font1 == 8'hc0, i_font0 == 8'hc0};
    always_comb begin
        case (idx_q)
            2'd3:    lead_zero = is_zero[3];
            2'd2:    lead_zero = &is_zero[3:2];
            2'd1:    lead_zero = &is_zero[3:1];
            default: lead_zero = 1'b0;
        endcase
    end
    assign latch_font = lead_zero ? 8'hff : font_sel;
`else
    assign latch_font = font_sel;
`endif

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? 24'd0 : cnt_q + 24'd1;
        state_d = state_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        tick_d  = 1'b0;
        com_d   = 4'b1111;
        font_d  = 8'hff;
        case (state_q)
            ST_BLANK: begin
                // Font is sampled once per slot so mid-slot input changes cannot glitch.
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    latch_d = latch_font;
                end
            end
            default: begin
                if (!i_blank) begin
                    com_d  = ~(4'b0001 << idx_q);
                    font_d = latch_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                    tick_d  = (idx_q == 2'd3);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= 24'd0;
            idx_q   <= 2'd0;
            latch_q <= 8'hff;
            com_q   <= 4'b1111;
            font_q  <= 8'hff;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            com_q   <= com_d;
            font_q  <= font_d;
            tick_q  <= tick_d;
        end
    end

    assign o_fnd_com    = com_q;
    assign o_fnd_font   = font_q;
    assign o_digit_idx  = idx_q;
    assign o_frame_tick = tick_q;

endmodule
